// File: rtl/pm_domain_sequencer_if.sv
// Signal bundle between the always-on PM controller (master) and the domain sequencer (slave).
// Carries the power-down request, switch-chain acknowledge and all domain control outputs.
interface pm_domain_sequencer_if;
  logic PD_REQ;
  logic SW_ACK;
  logic CLK_EN;
  logic ISO_EN;
  logic RET_SAVE;
  logic RET_RESTORE;
  logic SWITCH_EN;
  logic PD_ACK;
  logic BUSY;
  logic ERR;

  modport master (
    output PD_REQ,
    output SW_ACK,
    input  CLK_EN,
    input  ISO_EN,
    input  RET_SAVE,
    input  RET_RESTORE,
    input  SWITCH_EN,
    input  PD_ACK,
    input  BUSY,
    input  ERR
  );

  modport slave (
    input  PD_REQ,
    input  SW_ACK,
    output CLK_EN,
    output ISO_EN,
    output RET_SAVE,
    output RET_RESTORE,
    output SWITCH_EN,
    output PD_ACK,
    output BUSY,
    output ERR
  );
endinterface

// File: rtl/pm_domain_sequencer.sv
// Power-down / power-up sequencer for one switchable domain (clock gate, isolation, retention, switch).
// Define PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN to add the switch-acknowledge timeout and ERROR state.
module pm_domain_sequencer #(
  parameter int unsigned SYNC_DEPTH     = 3,
  parameter int unsigned STEP_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                 CLK,
  input  logic                 RST,
  pm_domain_sequencer_if.slave pm
);

  // state      | meaning
  // ON         | domain powered and clocked, waiting for a power-down request
  // GATE       | clock gated, dwell STEP_CYCLES
  // ISO        | isolation enabled, dwell STEP_CYCLES
  // SAVE       | retention save strobe, dwell STEP_CYCLES
  // SW_OFF     | switch opened, waiting for the chain to report unpowered
  // OFF        | domain fully off, waiting for a power-up request
  // SW_ON      | switch closed, waiting for the chain to report powered
  // RESTORE    | retention restore strobe, dwell STEP_CYCLES
  // DEISO      | isolation released, dwell STEP_CYCLES
  // UNGATE     | clock re-enabled for one cycle before returning to ON
  // ERROR      | switch acknowledge timed out; outputs frozen until reset (timeout build only)

  typedef enum logic [3:0] {
    ST_ON,
    ST_GATE,
    ST_ISO,
    ST_SAVE,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RESTORE,
    ST_DEISO,
    ST_UNGATE
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
    , ST_ERROR
`endif
  } state_t;

  if (SYNC_DEPTH < 2 || SYNC_DEPTH > 4) begin : g_bad_sync_depth
    $error("pm_domain_sequencer: SYNC_DEPTH must be within 2..4");
  end
  if (STEP_CYCLES < 1 || STEP_CYCLES > 255) begin : g_bad_step_cycles
    $error("pm_domain_sequencer: STEP_CYCLES must be within 1..255");
  end
  if ((64'd1 << CNT_W) <= 64'(STEP_CYCLES) || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
    $error("pm_domain_sequencer: CNT_W too narrow for STEP_CYCLES/TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cnt_run;
  logic                  step_done;
  logic [SYNC_DEPTH-1:0] pd_sync_q, pd_sync_d;
  logic [SYNC_DEPTH-1:0] ack_sync_q, ack_sync_d;
  logic                  pd_req_s, sw_ack_s;

  logic clk_en_q, clk_en_d;
  logic iso_en_q, iso_en_d;
  logic ret_save_q, ret_save_d;
  logic ret_restore_q, ret_restore_d;
  logic switch_en_q, switch_en_d;
  logic pd_ack_q, pd_ack_d;
  logic busy_q, busy_d;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
  logic err_q, err_d;
`endif

  always_comb begin
    pd_sync_d  = {pd_sync_q[SYNC_DEPTH-2:0], pm.PD_REQ};
    ack_sync_d = {ack_sync_q[SYNC_DEPTH-2:0], pm.SW_ACK};
    pd_req_s   = pd_sync_q[SYNC_DEPTH-1];
    sw_ack_s   = ack_sync_q[SYNC_DEPTH-1];
  end

  assign step_done = (cnt_q == STEP_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ON:      if (pd_req_s)  state_d = ST_GATE;
      ST_GATE:    if (step_done) state_d = ST_ISO;
      ST_ISO:     if (step_done) state_d = ST_SAVE;
      ST_SAVE:    if (step_done) state_d = ST_SW_OFF;
      ST_SW_OFF: begin
        if (!sw_ack_s) state_d = ST_OFF;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) state_d = ST_ERROR;
`endif
      end
      ST_OFF:     if (!pd_req_s) state_d = ST_SW_ON;
      ST_SW_ON: begin
        if (sw_ack_s) state_d = ST_RESTORE;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) state_d = ST_ERROR;
`endif
      end
      ST_RESTORE: if (step_done) state_d = ST_DEISO;
      ST_DEISO:   if (step_done) state_d = ST_UNGATE;
      ST_UNGATE:  state_d = ST_ON;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
      ST_ERROR:   state_d = ST_ERROR;
`endif
      default:    state_d = ST_ON;
    endcase
  end

  // Counter restarts from zero on every state entry and only runs where a dwell or timeout matters.
  always_comb begin
    cnt_run = 1'b0;
    case (state_q)
      ST_GATE, ST_ISO, ST_SAVE, ST_RESTORE, ST_DEISO: cnt_run = 1'b1;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
      ST_SW_OFF, ST_SW_ON: cnt_run = 1'b1;
`endif
      default: cnt_run = 1'b0;
    endcase
    cnt_d = '0;
    if (cnt_run && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    clk_en_d      = 1'b0;
    iso_en_d      = 1'b0;
    ret_save_d    = 1'b0;
    ret_restore_d = 1'b0;
    switch_en_d   = 1'b1;
    pd_ack_d      = 1'b0;
    busy_d        = 1'b1;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
    err_d         = 1'b0;
`endif
    case (state_d)
      ST_ON: begin
        clk_en_d = 1'b1;
        busy_d   = 1'b0;
      end
      ST_GATE: ;
      ST_ISO:  iso_en_d = 1'b1;
      ST_SAVE: begin
        iso_en_d   = 1'b1;
        ret_save_d = 1'b1;
      end
      ST_SW_OFF: begin
        iso_en_d    = 1'b1;
        switch_en_d = 1'b0;
      end
      ST_OFF: begin
        iso_en_d    = 1'b1;
        switch_en_d = 1'b0;
        pd_ack_d    = 1'b1;
        busy_d      = 1'b0;
      end
      ST_SW_ON: iso_en_d = 1'b1;
      ST_RESTORE: begin
        iso_en_d      = 1'b1;
        ret_restore_d = 1'b1;
      end
      ST_DEISO:  ;
      ST_UNGATE: clk_en_d = 1'b1;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
      // Domain stays exactly as the timed-out step left it.
      ST_ERROR: begin
        clk_en_d      = clk_en_q;
        iso_en_d      = iso_en_q;
        ret_save_d    = ret_save_q;
        ret_restore_d = ret_restore_q;
        switch_en_d   = switch_en_q;
        pd_ack_d      = pd_ack_q;
        busy_d        = 1'b0;
        err_d         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_ON;
      cnt_q         <= '0;
      pd_sync_q     <= '0;
      ack_sync_q    <= '0;
      clk_en_q      <= 1'b1;
      iso_en_q      <= 1'b0;
      ret_save_q    <= 1'b0;
      ret_restore_q <= 1'b0;
      switch_en_q   <= 1'b1;
      pd_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pd_sync_q     <= pd_sync_d;
      ack_sync_q    <= ack_sync_d;
      clk_en_q      <= clk_en_d;
      iso_en_q      <= iso_en_d;
      ret_save_q    <= ret_save_d;
      ret_restore_q <= ret_restore_d;
      switch_en_q   <= switch_en_d;
      pd_ack_q      <= pd_ack_d;
      busy_q        <= busy_d;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign pm.CLK_EN      = clk_en_q;
  assign pm.ISO_EN      = iso_en_q;
  assign pm.RET_SAVE    = ret_save_q;
  assign pm.RET_RESTORE = ret_restore_q;
  assign pm.SWITCH_EN   = switch_en_q;
  assign pm.PD_ACK      = pd_ack_q;
  assign pm.BUSY        = busy_q;
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
  assign pm.ERR         = err_q;
`else
  assign pm.ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_pm_domain_sequencer.sv
// Bench for pm_domain_sequencer: directed timing checks plus randomized traffic against a sequence-list model.
// Honours PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN the same way as the design.
module tb_pm_domain_sequencer;
  localparam int SYNC = 3;
  localparam int STEP = 4;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pm_domain_sequencer_if pm_if ();

  pm_domain_sequencer #(
    .SYNC_DEPTH(SYNC), .STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TMO), .CNT_W(11)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .pm (pm_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int rel      = 0;

  // Sequence order ON,GATE,ISO,SAVE,SW_OFF,OFF,SW_ON,RESTORE,DEISO,UNGATE.
  // Output bits: {CLK_EN, ISO_EN, RET_SAVE, RET_RESTORE, SWITCH_EN, PD_ACK, BUSY, ERR}.
  logic [7:0] out_tab [10] = '{8'b1000_1000, 8'b0000_1010, 8'b0100_1010, 8'b0110_1010,
                               8'b0100_0010, 8'b0100_0100, 8'b0100_1010, 8'b0101_1010,
                               8'b0000_1010, 8'b1000_1010};
  int dwell [10] = '{0, STEP, STEP, STEP, 0, 0, 0, STEP, STEP, 1};

  int         m_phase = 0;
  int         m_left  = 0;
  int         m_wait  = 0;
  bit         m_err   = 0;
  logic [7:0] m_out   = 8'b1000_1000;
  bit         pd_hist [$];
  bit         ack_hist [$];
  bit         m_pd_s, m_ack_s, m_adv;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_wait = 0; m_err = 0;
      m_out   = out_tab[0];
      pd_hist.delete(); ack_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
        pd_hist.push_back(1'b0); ack_hist.push_back(1'b0);
      end
    end else begin
      m_pd_s  = pd_hist.pop_front();
      m_ack_s = ack_hist.pop_front();
      pd_hist.push_back(pm_if.PD_REQ);
      ack_hist.push_back(pm_if.SW_ACK);
      if (!m_err) begin
        m_adv = 1'b0;
        if (dwell[m_phase] != 0) begin
          m_left = m_left - 1;
          m_adv  = (m_left == 0);
        end else begin
          case (m_phase)
            0: m_adv = m_pd_s;
            4: m_adv = !m_ack_s;
            5: m_adv = !m_pd_s;
            6: m_adv = m_ack_s;
            default: m_adv = 1'b0;
          endcase
        end
        if (m_adv) begin
          m_phase = (m_phase + 1) % 10;
          m_left  = dwell[m_phase];
          m_wait  = 0;
          m_out   = out_tab[m_phase];
        end
`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
        else if (m_phase == 4 || m_phase == 6) begin
          m_wait = m_wait + 1;
          if (m_wait == TMO) begin
            m_err = 1'b1;
            m_out = {m_out[7:2], 2'b01};
          end
        end
`endif
      end
    end
  end

  function automatic logic [7:0] dut_out();
    return {pm_if.CLK_EN, pm_if.ISO_EN, pm_if.RET_SAVE, pm_if.RET_RESTORE,
            pm_if.SWITCH_EN, pm_if.PD_ACK, pm_if.BUSY, pm_if.ERR};
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every clock: advance one edge, then compare all outputs against the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    checks++;
    if (dut_out() !== m_out) begin
      failures++;
      $display("FAIL model_cmp: got %b expected %b (t=%0t)", dut_out(), m_out, $time);
    end
  endtask

  task automatic go_rel(input int k);
    while (rel < k) begin
      cycle();
      rel++;
    end
  endtask

  bit saw_ack, back_on, aborted;
  int r;

  initial begin
    pm_if.PD_REQ = 1'b0;
    pm_if.SW_ACK = 1'b1;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_clk_en", pm_if.CLK_EN, 1'b1);
    chk("rst_switch_en", pm_if.SWITCH_EN, 1'b1);
    chk("rst_iso_en", pm_if.ISO_EN, 1'b0);
    chk("rst_busy", pm_if.BUSY, 1'b0);
    chk("rst_pd_ack", pm_if.PD_ACK, 1'b0);
    chk("rst_err", pm_if.ERR, 1'b0);

    // Power-down timing; the edge just passed is edge 0.
    rel = 0; pm_if.PD_REQ = 1'b1;
    go_rel(3);  chk("pd_clk_en_e3", pm_if.CLK_EN, 1'b1); chk("pd_busy_e3", pm_if.BUSY, 1'b0);
    go_rel(4);  chk("pd_clk_en_e4", pm_if.CLK_EN, 1'b0); chk("pd_busy_e4", pm_if.BUSY, 1'b1);
    go_rel(7);  chk("pd_iso_e7", pm_if.ISO_EN, 1'b0);
    go_rel(8);  chk("pd_iso_e8", pm_if.ISO_EN, 1'b1);
    go_rel(11); chk("pd_save_e11", pm_if.RET_SAVE, 1'b0);
    go_rel(12); chk("pd_save_e12", pm_if.RET_SAVE, 1'b1);
    go_rel(15); chk("pd_save_e15", pm_if.RET_SAVE, 1'b1); chk("pd_sw_e15", pm_if.SWITCH_EN, 1'b1);
    go_rel(16); chk("pd_save_e16", pm_if.RET_SAVE, 1'b0); chk("pd_sw_e16", pm_if.SWITCH_EN, 1'b0);
    chk("pd_busy_e16", pm_if.BUSY, 1'b1);
    go_rel(20); pm_if.SW_ACK = 1'b0;
    go_rel(23); chk("pd_ack_e23", pm_if.PD_ACK, 1'b0);
    go_rel(24); chk("pd_ack_e24", pm_if.PD_ACK, 1'b1); chk("pd_busy_e24", pm_if.BUSY, 1'b0);
    chk("pd_off_clk_en", pm_if.CLK_EN, 1'b0); chk("pd_off_iso", pm_if.ISO_EN, 1'b1);

    // Power-up timing from OFF.
    go_rel(30);
    rel = 0; pm_if.PD_REQ = 1'b0;
    go_rel(3);  chk("pu_sw_e3", pm_if.SWITCH_EN, 1'b0); chk("pu_ack_e3", pm_if.PD_ACK, 1'b1);
    go_rel(4);  chk("pu_sw_e4", pm_if.SWITCH_EN, 1'b1); chk("pu_ack_e4", pm_if.PD_ACK, 1'b0);
    go_rel(10); pm_if.SW_ACK = 1'b1;
    go_rel(13); chk("pu_rest_e13", pm_if.RET_RESTORE, 1'b0);
    go_rel(14); chk("pu_rest_e14", pm_if.RET_RESTORE, 1'b1);
    go_rel(17); chk("pu_rest_e17", pm_if.RET_RESTORE, 1'b1); chk("pu_iso_e17", pm_if.ISO_EN, 1'b1);
    go_rel(18); chk("pu_rest_e18", pm_if.RET_RESTORE, 1'b0); chk("pu_iso_e18", pm_if.ISO_EN, 1'b0);
    go_rel(21); chk("pu_clk_en_e21", pm_if.CLK_EN, 1'b0);
    go_rel(22); chk("pu_clk_en_e22", pm_if.CLK_EN, 1'b1); chk("pu_busy_e22", pm_if.BUSY, 1'b1);
    go_rel(23); chk("pu_busy_e23", pm_if.BUSY, 1'b0); chk("pu_clk_en_e23", pm_if.CLK_EN, 1'b1);

    // Reset pulse while in SAVE.
    go_rel(28);
    rel = 0; pm_if.PD_REQ = 1'b1;
    go_rel(13); chk("rm_in_save", pm_if.RET_SAVE, 1'b1);
    rst = 1'b1; pm_if.PD_REQ = 1'b0;
    go_rel(14); rst = 1'b0;
    chk("rm_clk_en", pm_if.CLK_EN, 1'b1); chk("rm_switch_en", pm_if.SWITCH_EN, 1'b1);
    chk("rm_iso_en", pm_if.ISO_EN, 1'b0); chk("rm_ret_save", pm_if.RET_SAVE, 1'b0);
    chk("rm_busy", pm_if.BUSY, 1'b0);
    go_rel(24); chk("rm_stays_on", pm_if.BUSY, 1'b0);

`ifdef PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN
    // SW_ACK stuck high: timeout 16 cycles after SW_OFF entry at edge 16.
    rel = 0; pm_if.PD_REQ = 1'b1; pm_if.SW_ACK = 1'b1;
    go_rel(31); chk("to_err_e31", pm_if.ERR, 1'b0); chk("to_busy_e31", pm_if.BUSY, 1'b1);
    go_rel(32); chk("to_err_e32", pm_if.ERR, 1'b1); chk("to_busy_e32", pm_if.BUSY, 1'b0);
    chk("to_sw_e32", pm_if.SWITCH_EN, 1'b0);
    for (int i = 0; i < 6; i++) begin
      pm_if.PD_REQ = ~pm_if.PD_REQ;
      go_rel(38 + 6 * i);
    end
    chk("to_err_held", pm_if.ERR, 1'b1); chk("to_sw_held", pm_if.SWITCH_EN, 1'b0);
    chk("to_pd_ack_held", pm_if.PD_ACK, 1'b0);
    pm_if.PD_REQ = 1'b0; rst = 1'b1;
    cycle(); rst = 1'b0;
    chk("to_rst_err", pm_if.ERR, 1'b0); chk("to_rst_clk_en", pm_if.CLK_EN, 1'b1);
    repeat (5) cycle();
`endif

    // Request held for 8 cycles only: the full sequence must still complete, then power back up.
    saw_ack = 0; back_on = 0; aborted = 0;
    pm_if.PD_REQ = 1'b1;
    for (int i = 0; i < 200 && !back_on; i++) begin
      if (i == 8) pm_if.PD_REQ = 1'b0;
      cycle();
      pm_if.SW_ACK = pm_if.SWITCH_EN;
      if (pm_if.PD_ACK) saw_ack = 1;
      if (!saw_ack && i > 5 && !pm_if.BUSY) aborted = 1;
      if (saw_ack && pm_if.CLK_EN && !pm_if.BUSY) back_on = 1;
    end
    chk("rev_reached_off", saw_ack, 1'b1);
    chk("rev_no_abort", aborted, 1'b0);
    chk("rev_back_on", back_on, 1'b1);

    // Random traffic: PD_REQ toggles, lagging/spurious SW_ACK, rare reset while not off.
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if ($urandom_range(0, 19) == 0) pm_if.PD_REQ = ~pm_if.PD_REQ;
      r = $urandom_range(0, 31);
      if (r < 8) pm_if.SW_ACK = pm_if.SWITCH_EN;
      else if (r == 31) pm_if.SW_ACK = ~pm_if.SW_ACK;
      rst = (!pm_if.PD_ACK && $urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pm_domain_sequencer.md
Name: pm_domain_sequencer

Overview:
- Power-management controller that sequences power-down and power-up of one switchable domain.
- Steps, in order: clock gating, isolation, retention save/restore, power-switch control.
- Power-down request and power-switch acknowledge are asynchronous, so the block re-times each through an internal SYNC_DEPTH-stage synchroniser chain.
- Sits between the always-on PM controller and the domain's clock gate, isolation cells, retention flops and switch chain.

Parameters:
- SYNC_DEPTH, 3, synchroniser stages on PD_REQ and SW_ACK (legal range 2..4).
- STEP_CYCLES, 4, dwell cycles in each timed state (legal range 1..255).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for SW_ACK (used only with the optional feature).
- CNT_W, 11, counter width; must satisfy 2^CNT_W > max(STEP_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLK  in  1  always-on clock.
- RST  in  1  reset, synchronous, active-high.
- PD_REQ  in  1  async level request: 1 = power down, 0 = power up.
- SW_ACK  in  1  async switch-chain acknowledge: 1 = domain powered.
- CLK_EN  out  1  domain clock enable.
- ISO_EN  out  1  isolation enable.
- RET_SAVE  out  1  retention save strobe (level for STEP_CYCLES).
- RET_RESTORE  out  1  retention restore strobe (level for STEP_CYCLES).
- SWITCH_EN  out  1  power switch enable.
- PD_ACK  out  1  domain fully off.
- BUSY  out  1  sequence in progress.
- ERR  out  1  acknowledge timeout (tied 0 without the optional feature).

Behaviour:
- **Synchronisers:** both inputs pass through SYNC_DEPTH flops; all flops clear to 0 on RST. The synchronised PD_REQ is visible SYNC_DEPTH edges after the input settles.
- **Output coding:** all outputs are registered and decoded from next state, so they change on the edge the state is entered.
- **FSM states:** ON, GATE, ISO, SAVE, SW_OFF, OFF, SW_ON, RESTORE, DEISO, UNGATE, ERROR.
- **Reset:** state ON. CLK_EN=1, SWITCH_EN=1, all other outputs 0. Counter = 0.
- **ON:**
  - Outputs: CLK_EN=1, ISO_EN=0, SWITCH_EN=1.
  - Synchronised PD_REQ=1 -> GATE.
- **GATE:** CLK_EN=0. After STEP_CYCLES cycles -> ISO.
- **ISO:** ISO_EN=1. After STEP_CYCLES cycles -> SAVE.
- **SAVE:** RET_SAVE=1. After STEP_CYCLES cycles -> SW_OFF.
- **SW_OFF:**
  - RET_SAVE=0, SWITCH_EN=0.
  - Wait for synchronised SW_ACK=0, then -> OFF.
- **OFF:**
  - PD_ACK=1. CLK_EN=0, ISO_EN=1, SWITCH_EN=0.
  - Synchronised PD_REQ=0 -> SW_ON.
- **SW_ON:**
  - PD_ACK=0, SWITCH_EN=1.
  - Wait for synchronised SW_ACK=1, then -> RESTORE.
- **RESTORE:** RET_RESTORE=1. After STEP_CYCLES cycles -> DEISO.
- **DEISO:** RET_RESTORE=0, ISO_EN=0. After STEP_CYCLES cycles -> UNGATE.
- **UNGATE:** CLK_EN=1. Next cycle -> ON.
- **Dwell counting:**
  - Counter loads 0 on every state entry and increments each cycle.
  - A timed state exits on the edge where counter == STEP_CYCLES-1.
  - It therefore dwells exactly STEP_CYCLES cycles.
- **BUSY:** 1 in every state except ON and OFF.
- **Request changes mid-sequence:** ignored. A sequence always completes to ON or OFF, then the synchronised PD_REQ is re-evaluated; there is no abort path.
- **PD_REQ glitches:** a pulse shorter than one cycle may be missed; PD_REQ is specified as a level held until the matching PD_ACK change.
- **RST mid-sequence:**
  - Forces state ON with reset outputs on the next edge, regardless of current state.
  - The system must hold RST only while the domain is powered.
- **Spurious SW_ACK:** changes of SW_ACK outside SW_OFF/SW_ON have no effect.

Optional Feature:
- Macro: PM_DOMAIN_SEQUENCER_ACK_TIMEOUT_EN.
- **Defined:**
  - The counter also runs in SW_OFF and SW_ON.
  - If the counter reaches TIMEOUT_CYCLES-1 before the acknowledge arrives -> ERROR.
  - ERROR: ERR=1, BUSY=0. Outputs frozen at the values of the state that timed out.
  - ERROR is left only by RST.
- **Undefined:**
  - SW_OFF/SW_ON wait indefinitely.
  - ERR is constant 0 and the ERROR state does not exist.

Test Plan:
- **Power-down timing:** defaults; RST then PD_REQ=1 sampled at edge 0, SW_ACK held 1.
  - Required: CLK_EN falls at edge 4, ISO_EN rises at edge 8, RET_SAVE high over edges 12-15, SWITCH_EN falls at edge 16, BUSY=1 throughout.
- **Power-down completion:** from the previous test, drop SW_ACK at edge 20.
  - Required: PD_ACK=1 at edge 24, BUSY=0, CLK_EN=0, ISO_EN=1.
- **Power-up timing:** from OFF, PD_REQ=0 at edge 0, SW_ACK rises at edge 10.
  - Required: SWITCH_EN=1 at edge 4, PD_ACK=0 at edge 4, RET_RESTORE high over edges 14-17, ISO_EN=0 at edge 18, CLK_EN=1 at edge 22, state ON at edge 23.
- **Request reversal mid-sequence:** PD_REQ pulsed 1 for 8 cycles, then 0.
  - Required: full power-down completes to PD_ACK=1, then an immediate power-up follows with no intermediate abort.
- **Reset mid-sequence:** RST asserted for 1 cycle during SAVE.
  - Required: next edge CLK_EN=1, SWITCH_EN=1, ISO_EN=0, RET_SAVE=0, BUSY=0.
- **Ack timeout (macro defined):** TIMEOUT_CYCLES=16, SW_ACK stuck at 1 in SW_OFF.
  - Required: ERR=1 exactly 16 cycles after SW_OFF entry, SWITCH_EN stays 0, and PD_REQ toggles are ignored until RST.
